pipelined_memory: RTL and testbench
===================================

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 7, word-address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter LATENCY, default 1, legal range 1..4, cycles from request acceptance to response valid.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  DATA_W/8  byte enables, bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  DATA_W  response data.

Function
REQ-015 FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 req_ready SHALL be 1 exactly when state is IDLE; decoded from state only, no dependence on req_valid.
REQ-017 Acceptance SHALL occur on a posedge where state is IDLE and req_valid=1; req_* sampled at that edge only.
REQ-018 Accepted write SHALL update, at the acceptance edge, only bytes with req_be=1; others unchanged.
REQ-019 Accepted write with req_be all zero SHALL leave memory unchanged and still produce a response.
REQ-020 At the acceptance edge, the response register SHALL capture: for reads, the stored word; for writes, the merged word after the write.
REQ-021 LATENCY=1: IDLE -> RESP at acceptance edge; rsp_valid high in the cycle after acceptance.
REQ-022 LATENCY>1: IDLE -> WAIT at acceptance edge, down-counter loaded with LATENCY-1; WAIT -> RESP on the edge where counter reaches 0; rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-023 Counter width SHALL be $clog2(LATENCY)+1 bits and SHALL not wrap.
REQ-024 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-025 RESP -> IDLE on an edge with rsp_ready=1; a new request SHALL NOT be accepted on that same edge (req_ready was 0).
REQ-026 Maximum throughput: one transaction per LATENCY+1 cycles with rsp_ready held at 1.
REQ-027 rsp_ready while not in RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored with no memory effect.
REQ-028 rsp_rdata SHALL hold its last value after the response handshake until the next acceptance edge.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, req_ready=1.
REQ-030 Memory array contents SHALL NOT be altered by reset; array SHALL NOT be initialised by the RTL.
REQ-031 Reset in WAIT or RESP SHALL drop the pending response; the write of an already accepted request SHALL remain committed.
REQ-032 First acceptance possible on the first posedge after rst_n deasserts.

Verification (DATA_W=16, ADDR_W=7, LATENCY=2 unless stated)
REQ-033 Write 'hF201 to addr 0, be=11; then read addr 0 -> read rsp_valid 2 cycles after acceptance, rsp_rdata='hF201.
REQ-034 Preload addr 5='hB100; write 'h00AA be=01 -> write response 'hB1AA; read addr 5 -> 'hB1AA.
REQ-035 Read response with rsp_ready low 3 cycles -> rsp_valid and rsp_rdata held 3 cycles, req_ready 0 throughout, extra req_valid ignored.
REQ-036 Back-to-back reads, rsp_ready=1, LATENCY=1 and LATENCY=4 builds -> acceptances every 2 and 5 cycles respectively.
REQ-037 rst_n low during WAIT after write 'h1234 to addr 3 -> rsp_valid 0 immediately, req_ready 1; later read addr 3 -> 'h1234.
REQ-038 Write with be=00 to addr 7 holding 'hB120 -> write response 'hB120, memory unchanged.

Source files
------------

// File: rtl/pipelined_memory_if.sv
// Request/response bus for pipelined_memory: one request channel, one response channel.
interface pipelined_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;

  // Requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Memory side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/pipelined_memory.sv
// Single-port word memory with byte enables and a fixed-latency response path.
// At most one request is in flight: IDLE accepts, WAIT models latency, RESP holds
// the response until the consumer takes it.
module pipelined_memory #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_memory_if.slave bus
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned CntW     = $clog2(LATENCY) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged_word;
  logic                accept;

  // Acceptance is blocked while reset is asserted so the unreset array cannot be
  // written by a request presented during reset.
  assign accept = (state_q == StIdle) && bus.req_valid && rst_n;

  // Read the addressed word and overlay enabled write bytes on it.
  always_comb begin
    rd_word     = mem_q[bus.req_addr];
    merged_word = rd_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (bus.req_be[i]) begin
        merged_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Memory array: written only at acceptance, never reset or initialised.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we) begin
      mem_q[bus.req_addr] <= merged_word;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        // Leave on the edge that takes the counter from 1 to 0.
        if (cnt_q == CntOne) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from state alone.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rsp_rdata_q;
  end

  // Latency down-counter next value; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CntLoad;
    end else if ((state_q == StWait) && (cnt_q != CntZero)) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Latency counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Response data: captured at acceptance, held until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_rdata_q <= bus.req_we ? merged_word : rd_word;
    end
  end

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench: main checks on a LATENCY=2 instance, throughput checks on
// LATENCY=1 and LATENCY=4 instances.
module tb_pipelined_memory;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_memory_if #(.DATA_W(16), .ADDR_W(7)) bus2 ();
  pipelined_memory_if #(.DATA_W(16), .ADDR_W(7)) bus1 ();
  pipelined_memory_if #(.DATA_W(16), .ADDR_W(7)) bus4 ();

  pipelined_memory #(.DATA_W(16), .ADDR_W(7), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  pipelined_memory #(.DATA_W(16), .ADDR_W(7), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  pipelined_memory #(.DATA_W(16), .ADDR_W(7), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with rsp_ready held high.
  // Entered and left #1 after a posedge with the DUT idle.
  task automatic txn(input logic we, input logic [6:0] addr, input logic [15:0] wd,
                     input logic [1:0] be, output logic [15:0] rd, output int lat);
    bus2.req_we    = we;
    bus2.req_addr  = addr;
    bus2.req_wdata = wd;
    bus2.req_be    = be;
    bus2.req_valid = 1'b1;
    chk("req_ready_before_accept", 32'(bus2.req_ready), 32'd1);
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = 1;
    while (!bus2.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus2.rsp_rdata;
    @(posedge clk); #1;
  endtask

  logic [15:0] rd;
  int          lat;
  int          acc1[$];
  int          acc4[$];

  initial begin
    vecs[0]  = '{1'b1, 7'd0,   16'hF201, 2'b11, 16'hF201};
    vecs[1]  = '{1'b0, 7'd0,   16'h0000, 2'b00, 16'hF201};
    vecs[2]  = '{1'b1, 7'd5,   16'hB100, 2'b11, 16'hB100};
    vecs[3]  = '{1'b1, 7'd5,   16'h00AA, 2'b01, 16'hB1AA};
    vecs[4]  = '{1'b0, 7'd5,   16'h0000, 2'b00, 16'hB1AA};
    vecs[5]  = '{1'b1, 7'd7,   16'hB120, 2'b11, 16'hB120};
    vecs[6]  = '{1'b1, 7'd7,   16'hFFFF, 2'b00, 16'hB120};
    vecs[7]  = '{1'b0, 7'd7,   16'h0000, 2'b00, 16'hB120};
    vecs[8]  = '{1'b1, 7'd9,   16'hA5A5, 2'b11, 16'hA5A5};
    vecs[9]  = '{1'b1, 7'd9,   16'h3C3C, 2'b10, 16'h3CA5};
    vecs[10] = '{1'b0, 7'd9,   16'h0000, 2'b00, 16'h3CA5};
    vecs[11] = '{1'b1, 7'd127, 16'hFFFF, 2'b11, 16'hFFFF};
    vecs[12] = '{1'b0, 7'd127, 16'h0000, 2'b00, 16'hFFFF};
    vecs[13] = '{1'b0, 7'd0,   16'h0000, 2'b00, 16'hF201};

    rst_n = 1'b0;
    bus2.req_valid = 0; bus2.req_we = 0; bus2.req_addr = 0; bus2.req_wdata = 0;
    bus2.req_be = 0; bus2.rsp_ready = 1;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    bus1.req_be = 0; bus1.rsp_ready = 1;
    bus4.req_valid = 0; bus4.req_we = 0; bus4.req_addr = 0; bus4.req_wdata = 0;
    bus4.req_be = 0; bus4.rsp_ready = 1;
    #1;
    chk("reset_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(bus2.rsp_rdata), 32'd0);
    chk("reset_l4_req_ready", 32'(bus4.req_ready), 32'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transactions.
    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp));
      chk($sformatf("v%0d_rdata_hold", i), 32'(bus2.rsp_rdata), 32'(vecs[i].exp));
      chk($sformatf("v%0d_idle_after", i), 32'(bus2.req_ready), 32'd1);
    end

    // Response back-pressure: rsp_ready low for 3 cycles with a stray write offered.
    bus2.rsp_ready = 1'b0;
    bus2.req_we = 1'b0; bus2.req_addr = 7'd5; bus2.req_be = 2'b00; bus2.req_valid = 1'b1;
    @(posedge clk); #1;
    bus2.req_we = 1'b1; bus2.req_wdata = 16'h0000; bus2.req_be = 2'b11;
    chk("bp_wait_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("bp_wait_req_ready", 32'(bus2.req_ready), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_rsp_valid", k), 32'(bus2.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_rdata", k), 32'(bus2.rsp_rdata), 32'hB1AA);
      chk($sformatf("bp%0d_req_ready", k), 32'(bus2.req_ready), 32'd0);
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    bus2.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(bus2.req_ready), 32'd1);
    chk("bp_release_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    txn(1'b0, 7'd5, 16'h0, 2'b00, rd, lat);
    chk("bp_stray_write_ignored", 32'(rd), 32'hB1AA);

    // Reset during WAIT after a write: response dropped, write kept.
    bus2.req_we = 1'b1; bus2.req_addr = 7'd3; bus2.req_wdata = 16'h1234;
    bus2.req_be = 2'b11; bus2.req_valid = 1'b1;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    chk("rst_wait_state_req_ready", 32'(bus2.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("rst_wait_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("rst_wait_rsp_rdata", 32'(bus2.rsp_rdata), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_no_late_rsp", 32'(bus2.rsp_valid), 32'd0);
    txn(1'b0, 7'd3, 16'h0, 2'b00, rd, lat);
    chk("rst_wait_write_kept", 32'(rd), 32'h1234);
    chk("rst_wait_read_latency", 32'(lat), 32'd2);

    // Throughput: continuous reads on LATENCY=1 and LATENCY=4 instances.
    bus1.req_valid = 1'b1;
    bus4.req_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus1.req_ready) acc1.push_back(k);
      if (bus4.req_ready) acc4.push_back(k);
    end
    bus1.req_valid = 1'b0;
    bus4.req_valid = 1'b0;
    chk("l1_accept_count", 32'(acc1.size()), 32'd15);
    chk("l4_accept_count", 32'(acc4.size()), 32'd6);
    for (int k = 1; k < acc1.size(); k++) begin
      chk($sformatf("l1_interval%0d", k), 32'(acc1[k] - acc1[k-1]), 32'd2);
    end
    for (int k = 1; k < acc4.size(); k++) begin
      chk($sformatf("l4_interval%0d", k), 32'(acc4[k] - acc4[k-1]), 32'd5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
